// File: rtl/spi_accel_pkg.sv
// Shared state encoding, command layout and register-map constants for the SPI accelerometer responder.
package spi_accel_pkg;

  typedef enum logic [1:0] {Idle, Command, Data} state_e;

  typedef struct packed {
    logic       rw;
    logic       mb;
    logic [5:0] addr;
  } cmd_t;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_WR_LO       = 6'h1D;
  localparam logic [5:0] ADDR_WR_HI       = 6'h31;
  localparam logic [7:0] BW_RATE_RST      = 8'h0A;
  localparam int         NUM_WR_REGS      = 21;

  function automatic logic is_writable(input logic [5:0] a);
    return (a >= ADDR_WR_LO) && (a <= ADDR_WR_HI);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Pin synchroniser into ipClk with single-cycle rise/fall strobes taken one stage past the sync chain.
// Level appears STAGES cycles after the pin; strobes are combinational from the last two stages.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic ipClk,
  input  logic ipReset,
  input  logic i_pin,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_lvl  = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-3 target emulating the accelerometer register map, fully oversampled in ipClk.
// Optional ACCEL_RESP_SNAPSHOT_EN: latch X/Y/Z at read-command decode so multi-byte reads do not tear.
module spi_accel_responder
  import spi_accel_pkg::*;
#(
  parameter int         Sync_Stages = 2,
  parameter logic [7:0] Dev_ID      = 8'hE5
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic        nCS,
  input  logic        SClk,
  input  logic        SDI,
  output logic        SDO,
  input  logic [15:0] ipX,
  input  logic [15:0] ipY,
  input  logic [15:0] ipZ,
  output logic [7:0]  opDataFormat,
  output logic        opWrValid,
  output logic [5:0]  opWrAddr,
  output logic [7:0]  opWrData
);

  localparam int BW_IDX = int'(ADDR_BW_RATE) - int'(ADDR_WR_LO);
  localparam int DF_IDX = int'(ADDR_DATA_FORMAT) - int'(ADDR_WR_LO);

  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_sck_lvl, w_sck_rise, w_sck_fall;
  logic w_sdi, w_sdi_rise, w_sdi_fall;
  logic w_unused;

  // nCS resets low so a frame in progress across reset is not mistaken for an idle bus.
  spi_pin_sync #(.STAGES(Sync_Stages), .RST_VAL(1'b0)) u_sync_cs (
    .ipClk(ipClk), .ipReset(ipReset), .i_pin(nCS),
    .o_lvl(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
  spi_pin_sync #(.STAGES(Sync_Stages), .RST_VAL(1'b1)) u_sync_sck (
    .ipClk(ipClk), .ipReset(ipReset), .i_pin(SClk),
    .o_lvl(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
  spi_pin_sync #(.STAGES(Sync_Stages), .RST_VAL(1'b0)) u_sync_sdi (
    .ipClk(ipClk), .ipReset(ipReset), .i_pin(SDI),
    .o_lvl(w_sdi), .o_rise(w_sdi_rise), .o_fall(w_sdi_fall));

  assign w_unused = &{w_sck_lvl, w_sdi_rise, w_sdi_fall};

  state_e      r_state, w_state_nxt;
  logic        r_armed;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_rx;
  cmd_t        r_cmd;
  logic [7:0]  r_tx;
  logic        r_fall_d;
  logic        r_sdo;
  logic [7:0]  r_regs [NUM_WR_REGS];
  logic        r_wr_vld;
  logic [5:0]  r_wr_addr;
  logic [7:0]  r_wr_dat;

  logic [7:0]  w_byte;
  logic        w_byte_done;
  logic        w_decode;
  cmd_t        w_cmd;
  logic [5:0]  w_next_addr;
  logic [5:0]  w_rd_addr;
  logic [7:0]  w_rd_dat;
  logic [2:0]  w_xyz_off;
  logic [47:0] w_live;
  logic [47:0] w_xyz;

  assign w_byte      = {r_rx, w_sdi};
  assign w_byte_done = (r_state != Idle) && w_sck_rise && (r_bit_cnt == 3'd7) && !w_cs_rise;
  assign w_decode    = (r_state == Command) && w_byte_done;
  assign w_cmd       = cmd_t'(w_byte);
  assign w_next_addr = r_cmd.mb ? (r_cmd.addr + 6'd1) : r_cmd.addr;
  assign w_rd_addr   = (r_state == Command) ? w_cmd.addr : w_next_addr;
  assign w_xyz_off   = 3'(w_rd_addr - ADDR_DATAX0);
  assign w_live      = {ipZ, ipY, ipX};

`ifdef ACCEL_RESP_SNAPSHOT_EN
  logic [47:0] r_snap;
  logic        r_snap_vld;

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      r_snap     <= '0;
      r_snap_vld <= 1'b0;
    end else if (r_state == Idle) begin
      r_snap_vld <= 1'b0;
    end else if (w_decode && w_cmd.rw &&
                 (w_cmd.addr >= ADDR_DATAX0) && (w_cmd.addr <= ADDR_DATAX0 + 6'd5)) begin
      r_snap     <= w_live;
      r_snap_vld <= 1'b1;
    end
  end

  // The decode-cycle load uses the live value, which is exactly what the snapshot captures.
  assign w_xyz = (r_snap_vld && (r_state == Data)) ? r_snap : w_live;
`else
  assign w_xyz = w_live;
`endif

  always_comb begin
    w_rd_dat = 8'h00;
    if (w_rd_addr == ADDR_DEVID)
      w_rd_dat = Dev_ID;
    else if (is_writable(w_rd_addr))
      w_rd_dat = r_regs[5'(w_rd_addr - ADDR_WR_LO)];
    else if ((w_rd_addr >= ADDR_DATAX0) && (w_rd_addr <= ADDR_DATAX0 + 6'd5))
      w_rd_dat = w_xyz[{w_xyz_off, 3'b000} +: 8];
  end

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) r_state <= Idle;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      Idle:    if (r_armed && w_cs_fall) w_state_nxt = Command;
      Command: if (w_byte_done) w_state_nxt = Data;
      Data:    w_state_nxt = Data;
      default: w_state_nxt = Idle;
    endcase
    if (w_cs_rise) w_state_nxt = Idle;
  end

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      r_armed   <= 1'b0;
      r_bit_cnt <= 3'd0;
      r_rx      <= 7'd0;
      r_cmd     <= '0;
      r_tx      <= 8'hFF;
      r_fall_d  <= 1'b0;
      r_sdo     <= 1'b1;
      r_wr_vld  <= 1'b0;
      r_wr_addr <= 6'd0;
      r_wr_dat  <= 8'd0;
      for (int i = 0; i < NUM_WR_REGS; i++)
        r_regs[i] <= (i == BW_IDX) ? BW_RATE_RST : 8'h00;
    end else begin
      r_wr_vld <= 1'b0;
      r_fall_d <= w_sck_fall && (r_state == Data) && r_cmd.rw;
      if (w_cs_lvl) r_armed <= 1'b1;
      if ((r_state == Idle) || w_cs_rise) begin
        r_bit_cnt <= 3'd0;
        r_sdo     <= 1'b1;
        r_fall_d  <= 1'b0;
      end else begin
        if (w_sck_rise) begin
          r_rx      <= w_byte[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        if (w_decode) begin
          r_cmd <= w_cmd;
          if (w_cmd.rw) r_tx <= w_rd_dat;
        end else if (w_byte_done) begin
          r_cmd.addr <= w_next_addr;
          if (r_cmd.rw) begin
            r_tx <= w_rd_dat;
          end else if (is_writable(r_cmd.addr)) begin
            r_regs[5'(r_cmd.addr - ADDR_WR_LO)] <= w_byte;
            r_wr_vld  <= 1'b1;
            r_wr_addr <= r_cmd.addr;
            r_wr_dat  <= w_byte;
          end
        end
        // Delayed fall strobe gives SDO its extra cycle after the detected edge.
        if (r_fall_d && r_cmd.rw) begin
          r_sdo <= r_tx[7];
          r_tx  <= {r_tx[6:0], 1'b1};
        end
      end
    end
  end

  assign SDO          = r_sdo;
  assign opWrValid    = r_wr_vld;
  assign opWrAddr     = r_wr_addr;
  assign opWrData     = r_wr_dat;
  assign opDataFormat = r_regs[DF_IDX];

endmodule

// File: tb/tb_spi_accel_responder.sv
// Randomised and directed bench for spi_accel_responder against a register-map level reference model.
module tb_spi_accel_responder;

  localparam int HP = 5;

  logic        ipClk;
  logic        ipReset, nCS, SClk, SDI;
  logic        SDO;
  logic [15:0] ipX, ipY, ipZ;
  logic [7:0]  opDataFormat;
  logic        opWrValid;
  logic [5:0]  opWrAddr;
  logic [7:0]  opWrData;

  int total = 0;
  int bad   = 0;

  byte unsigned mreg [64];
  byte unsigned tx_q[$], rx_q[$], exp_rx[$];
  logic [13:0]  wr_q[$], exp_wr[$];
  int           chg_at;
  logic [15:0]  chg_x;

  spi_accel_responder dut (
    .ipClk(ipClk), .ipReset(ipReset), .nCS(nCS), .SClk(SClk), .SDI(SDI), .SDO(SDO),
    .ipX(ipX), .ipY(ipY), .ipZ(ipZ), .opDataFormat(opDataFormat),
    .opWrValid(opWrValid), .opWrAddr(opWrAddr), .opWrData(opWrData));

  initial ipClk = 1'b0;
  always #5 ipClk = ~ipClk;

  always @(negedge ipClk) if (opWrValid === 1'b1) wr_q.push_back({opWrAddr, opWrData});

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit m_writable(input int a);
    return (a >= 'h1D) && (a <= 'h31);
  endfunction

  function automatic byte unsigned m_read(input int a);
    logic [47:0] xyz;
    xyz = {ipZ, ipY, ipX};
    if (a == 0) return 8'hE5;
    if (m_writable(a)) return mreg[a];
    if (a >= 'h32 && a <= 'h37) return xyz[(a - 'h32) * 8 +: 8];
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mreg[i] = 8'h00;
    mreg['h2C] = 8'h0A;
  endtask

  // Predicts SDO bytes and write strobes for tx_q, updating the model register file.
  task automatic model_frame();
    int a;
    bit rw, mb;
    exp_rx.delete();
    exp_wr.delete();
    rw = tx_q[0][7];
    mb = tx_q[0][6];
    a  = int'(tx_q[0][5:0]);
    exp_rx.push_back(8'hFF);
    for (int i = 1; i < tx_q.size(); i++) begin
      if (rw) begin
        exp_rx.push_back(m_read(a));
      end else begin
        exp_rx.push_back(8'hFF);
        if (m_writable(a)) begin
          mreg[a] = tx_q[i];
          exp_wr.push_back({6'(a), tx_q[i]});
        end
      end
      if (mb) a = (a + 1) % 64;
    end
  endtask

  task automatic sclk_bit(input logic b, output logic so);
    SClk = 1'b0;
    SDI  = b;
    repeat (HP) @(negedge ipClk);
    so   = SDO;
    SClk = 1'b1;
    repeat (HP) @(negedge ipClk);
  endtask

  task automatic spi_frame(input int nbits);
    logic so;
    byte unsigned cur;
    cur = 8'h00;
    rx_q.delete();
    wr_q.delete();
    nCS = 1'b0;
    repeat (HP) @(negedge ipClk);
    for (int i = 0; i < nbits; i++) begin
      if ((i / 8 == chg_at) && (i % 8 == 0)) ipX = chg_x;
      sclk_bit(tx_q[i / 8][7 - (i % 8)], so);
      cur = {cur[6:0], so};
      if (i % 8 == 7) rx_q.push_back(cur);
    end
    repeat (2 * HP) @(negedge ipClk);
    nCS = 1'b1;
    repeat (2 * HP) @(negedge ipClk);
  endtask

  task automatic test_reset();
    ipReset = 1'b1;
    repeat (4) @(negedge ipClk);
    ipReset = 1'b0;
    repeat (10) @(negedge ipClk);
    model_reset();
    total++; if (SDO !== 1'b1) begin bad++; $display("FAIL reset_sdo: got %b want 1", SDO); end
    total++; if (opWrValid !== 1'b0) begin bad++; $display("FAIL reset_wrvalid: got %b want 0", opWrValid); end
    total++; if (opWrAddr !== 6'h00) begin bad++; $display("FAIL reset_wraddr: got %h want 00", opWrAddr); end
    total++; if (opWrData !== 8'h00) begin bad++; $display("FAIL reset_wrdata: got %h want 00", opWrData); end
    total++; if (opDataFormat !== 8'h00) begin bad++; $display("FAIL reset_dataformat: got %h want 00", opDataFormat); end
  endtask

  task automatic test_write_format();
    tx_q = '{8'h31, 8'h09};
    model_frame();
    spi_frame(16);
    total++; if (wr_q.size() != 1) begin bad++; $display("FAIL wr_fmt_count: got %0d want 1", wr_q.size()); end
    else begin
      total++; if (wr_q[0] !== {6'h31, 8'h09}) begin bad++; $display("FAIL wr_fmt_strobe: got %h want %h", wr_q[0], {6'h31, 8'h09}); end
    end
    total++; if (opDataFormat !== mreg['h31]) begin bad++; $display("FAIL wr_fmt_reg: got %h want %h", opDataFormat, mreg['h31]); end
    total++; if (rx_q[1] !== 8'hFF) begin bad++; $display("FAIL wr_fmt_sdo: got %h want ff", rx_q[1]); end
  endtask

  task automatic test_read_devid();
    tx_q = '{8'h80, 8'h00};
    model_frame();
    spi_frame(16);
    total++; if (rx_q[0] !== 8'hFF) begin bad++; $display("FAIL devid_cmd_sdo: got %h want ff", rx_q[0]); end
    total++; if (rx_q[1] !== exp_rx[1]) begin bad++; $display("FAIL devid_data: got %h want %h", rx_q[1], exp_rx[1]); end
    total++; if (wr_q.size() != 0) begin bad++; $display("FAIL devid_nostrobe: got %0d want 0", wr_q.size()); end
  endtask

  task automatic test_read_xyz();
    ipX = 16'h1234; ipY = 16'hFFFE; ipZ = 16'h0100;
    tx_q = '{8'hF2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    model_frame();
    chg_x  = 16'hABCD;
    chg_at = 1;
`ifndef ACCEL_RESP_SNAPSHOT_EN
    exp_rx[2] = chg_x[15:8];
`endif
    spi_frame(56);
    chg_at = -1;
    for (int k = 1; k < 7; k++) begin
      total++;
      if (rx_q[k] !== exp_rx[k]) begin bad++; $display("FAIL xyz_byte%0d: got %h want %h", k, rx_q[k], exp_rx[k]); end
    end
  endtask

  task automatic test_mb0_write();
    tx_q = '{8'h1E, 8'hAA, 8'h55};
    model_frame();
    spi_frame(24);
    total++; if (wr_q.size() != 2) begin bad++; $display("FAIL mb0_count: got %0d want 2", wr_q.size()); end
    else begin
      for (int k = 0; k < 2; k++) begin
        total++;
        if (wr_q[k] !== exp_wr[k]) begin bad++; $display("FAIL mb0_strobe%0d: got %h want %h", k, wr_q[k], exp_wr[k]); end
      end
    end
    tx_q = '{8'h9E, 8'h00};
    model_frame();
    spi_frame(16);
    total++; if (rx_q[1] !== exp_rx[1]) begin bad++; $display("FAIL mb0_readback: got %h want %h", rx_q[1], exp_rx[1]); end
  endtask

  task automatic test_wrap_ro();
    tx_q = '{8'h7F, 8'h11, 8'h22};
    model_frame();
    spi_frame(24);
    total++; if (wr_q.size() != exp_wr.size()) begin bad++; $display("FAIL wrap_ro_count: got %0d want %0d", wr_q.size(), exp_wr.size()); end
  endtask

  task automatic test_abort();
    tx_q = '{8'h20, 8'h5A};
    model_frame();
    spi_frame(16);
    tx_q = '{8'h20, 8'hC3};
    spi_frame(13);
    total++; if (wr_q.size() != 0) begin bad++; $display("FAIL abort_nostrobe: got %0d want 0", wr_q.size()); end
    total++; if (SDO !== 1'b1) begin bad++; $display("FAIL abort_sdo: got %b want 1", SDO); end
    tx_q = '{8'hA0, 8'h00};
    model_frame();
    spi_frame(16);
    total++; if (rx_q[1] !== exp_rx[1]) begin bad++; $display("FAIL abort_readback: got %h want %h", rx_q[1], exp_rx[1]); end
    tx_q = '{8'h20, 8'h3C};
    model_frame();
    spi_frame(16);
    total++; if (wr_q.size() != 1 || wr_q[0] !== exp_wr[0]) begin bad++; $display("FAIL abort_next_write: got n=%0d want n=1 %h", wr_q.size(), exp_wr[0]); end
  endtask

  task automatic test_random();
    int nd;
    for (int f = 0; f < 20; f++) begin
      ipX = 16'($urandom); ipY = 16'($urandom); ipZ = 16'($urandom);
      tx_q.delete();
      tx_q.push_back(8'($urandom));
      nd = $urandom_range(1, 4);
      for (int k = 0; k < nd; k++) tx_q.push_back(8'($urandom));
      model_frame();
      spi_frame(8 * (nd + 1));
      for (int k = 0; k <= nd; k++) begin
        total++;
        if (rx_q[k] !== exp_rx[k]) begin bad++; $display("FAIL rand_rx f%0d b%0d cmd %h: got %h want %h", f, k, tx_q[0], rx_q[k], exp_rx[k]); end
      end
      total++;
      if (wr_q.size() != exp_wr.size()) begin
        bad++; $display("FAIL rand_wr_count f%0d cmd %h: got %0d want %0d", f, tx_q[0], wr_q.size(), exp_wr.size());
      end else begin
        for (int k = 0; k < wr_q.size(); k++) begin
          total++;
          if (wr_q[k] !== exp_wr[k]) begin bad++; $display("FAIL rand_wr f%0d s%0d: got %h want %h", f, k, wr_q[k], exp_wr[k]); end
        end
      end
      total++; if (opDataFormat !== mreg['h31]) begin bad++; $display("FAIL rand_fmt f%0d: got %h want %h", f, opDataFormat, mreg['h31]); end
    end
  endtask

  task automatic test_reset_midframe();
    logic        so;
    logic [15:0] sos;
    logic [15:0] wbits;
    byte unsigned cmd;
    cmd = 8'hAC;
    nCS = 1'b0;
    repeat (HP) @(negedge ipClk);
    for (int i = 0; i < 4; i++) sclk_bit(cmd[7 - i], so);
    ipReset = 1'b1;
    repeat (3) @(negedge ipClk);
    ipReset = 1'b0;
    repeat (HP) @(negedge ipClk);
    model_reset();
    total++; if (SDO !== 1'b1) begin bad++; $display("FAIL rst_mid_sdo: got %b want 1", SDO); end
    total++; if (opDataFormat !== mreg['h31]) begin bad++; $display("FAIL rst_mid_fmt: got %h want %h", opDataFormat, mreg['h31]); end
    wr_q.delete();
    wbits = 16'h3177;
    for (int i = 0; i < 16; i++) begin
      sclk_bit(wbits[15 - i], so);
      sos[15 - i] = so;
    end
    repeat (2 * HP) @(negedge ipClk);
    total++; if (sos !== 16'hFFFF) begin bad++; $display("FAIL rst_mid_sdo_idle: got %h want ffff", sos); end
    total++; if (wr_q.size() != 0) begin bad++; $display("FAIL rst_mid_nostrobe: got %0d want 0", wr_q.size()); end
    total++; if (opDataFormat !== mreg['h31]) begin bad++; $display("FAIL rst_mid_fmt_kept: got %h want %h", opDataFormat, mreg['h31]); end
    nCS = 1'b1;
    repeat (2 * HP) @(negedge ipClk);
    tx_q = '{8'hAC, 8'h00};
    model_frame();
    spi_frame(16);
    total++; if (rx_q[1] !== exp_rx[1]) begin bad++; $display("FAIL rst_mid_bwrate: got %h want %h", rx_q[1], exp_rx[1]); end
  endtask

  initial begin
    ipReset = 1'b1; nCS = 1'b1; SClk = 1'b1; SDI = 1'b0;
    ipX = 16'h0; ipY = 16'h0; ipZ = 16'h0;
    chg_at = -1; chg_x = 16'h0;
    test_reset();
    test_write_format();
    test_read_devid();
    test_read_xyz();
    test_mb0_write();
    test_wrap_ro();
    test_abort();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_accel_responder.md
Name: spi_accel_responder

Overview:
- SPI mode-3 (CPOL=1, CPHA=1), 4-wire target that emulates the accelerometer's register interface from the device side.
- Sits on the FPGA pins facing an external or on-chip SPI initiator; used as a bench/loopback model and as a real SPI peripheral exposing sensor data.
- All SPI pins are oversampled in the ipClk domain. No SClk-clocked logic.

Parameters:
- Sync_Stages, 2, flip-flop depth of the pin synchronisers (min 2).
- Dev_ID, 8'hE5, constant value returned at address 0x00.

Ports:
- ipClk, input, 1, system clock; must be at least 8x the SClk frequency.
- ipReset, input, 1, asynchronous active-high reset.
- nCS, input, 1, SPI chip select, active low.
- SClk, input, 1, SPI clock; idles high.
- SDI, input, 1, initiator-to-target data.
- SDO, output, 1, target-to-initiator data.
- ipX, input, 16, X sample, 2's complement.
- ipY, input, 16, Y sample, 2's complement.
- ipZ, input, 16, Z sample, 2's complement.
- opDataFormat, output, 8, current contents of register 0x31.
- opWrValid, output, 1, one-cycle strobe per accepted register write.
- opWrAddr, output, 6, address of the accepted write.
- opWrData, output, 8, data of the accepted write.

Behaviour:
- Reset values: SDO=1, opWrValid=0, opWrAddr=0, opWrData=0, opDataFormat=0x00, state=Idle. Writable registers reset to 0x00, except 0x2C which resets to 0x0A.
- Pin handling: nCS, SClk and SDI each pass through a Sync_Stages synchroniser. Rising and falling edges of synchronised SClk are detected with one extra register stage.
- After reset release, the bus is ignored until synchronised nCS has been seen high. This prevents joining a frame mid-way.
- SDI is sampled on each detected SClk rise. SDO updates on each detected SClk fall.
- States:
  - Idle -> Command when synchronised nCS falls.
  - Command: shift 8 bits MSB-first. Bit7 = R/W (1 = read), bit6 = MB, bits5:0 = address. On the 8th rise, decode and go to Data.
  - Data (read): the shift-out register is loaded with reg[addr] on the same cycle as the decode. The MSB is driven on the next SClk fall.
  - Data (write): shift in 8 bits. On the 8th rise, commit the byte.
  - Any state -> Idle when synchronised nCS rises.
- Address advance: after each completed data byte, address increments if MB=1 (wraps 0x3F -> 0x00). If MB=0 the address is held.
- Register map:
  - 0x00 reads Dev_ID.
  - 0x01-0x1C read 0x00.
  - 0x1D-0x31 are read/write.
  - 0x32-0x37 read {X lo, X hi, Y lo, Y hi, Z lo, Z hi}.
  - 0x38-0x3F read 0x00.
- Writes to read-only addresses are discarded and produce no strobe.
- Accepted write: register updates and opWrValid pulses on the ipClk cycle after the 8th-rise detection. opWrAddr and opWrData are valid with the strobe.
- SDO is 1 in Idle, during Command, and throughout write frames.
- nCS rising mid-byte: the partial byte is discarded, with no write and no strobe. State returns to Idle and SDO=1 on the next cycle.
- Asynchronous reset mid-frame: immediate return to reset values. The responder then re-arms only after nCS is seen high.
- Latency: pin edge to sample takes Sync_Stages+1 ipClk cycles. SClk fall to SDO change takes Sync_Stages+2 cycles.

Optional Feature:
- Macro: ACCEL_RESP_SNAPSHOT_EN.
- Defined: ipX, ipY and ipZ are latched into a 48-bit snapshot when a read command decodes with address in 0x32-0x37. Every data byte of that frame comes from the snapshot, so there is no tearing across a multi-byte read.
- Undefined: each byte is taken live from ipX/ipY/ipZ at its load cycle.

Decomposition:
- Package spi_accel_pkg holds:
  - state enum {Idle, Command, Data};
  - address constants ADDR_DEVID=0x00, ADDR_BW_RATE=0x2C, ADDR_DATA_FORMAT=0x31, ADDR_DATAX0=0x32;
  - writable-range bounds 0x1D and 0x31;
  - reset value 0x0A for BW_RATE.
- Sub-module spi_pin_sync: parameterised synchroniser plus rise/fall detector, instantiated for SClk, nCS and SDI.

Test Plan:
- Write frame {0x31, 0x09}, SClk = ipClk/10 -> opWrValid pulses once with opWrAddr=0x31, opWrData=0x09; opDataFormat=0x09.
- Read frame {0x80, 0x00} -> SDO returns 0xE5; no write strobe.
- ipX=0x1234, ipY=0xFFFE, ipZ=0x0100; read {0xF2, 6 dummy bytes} -> SDO returns 34 12 FE FF 00 01. With ACCEL_RESP_SNAPSHOT_EN, changing ipX mid-frame does not alter the returned bytes.
- Write MB=0 {0x1E, 0xAA, 0x55} -> two strobes, both at addr 0x1E; final value 0x55. Write {0x40|0x3F, 0x11, 0x22} -> wraps to 0x00; both writes target read-only addresses, so there are no strobes.
- nCS raised after 5 bits of a write data byte -> no strobe, register unchanged, SDO=1; the next full frame completes correctly.
- ipReset asserted mid-read with nCS held low, then released -> SDO=1 and registers at reset values; the responder ignores SClk until nCS goes high, then the following read of 0x2C returns 0x0A.
